// File: rtl/quad_dir_decoder.sv
// Quadrature A/B front end: synchronize, glitch-filter and decode Gray steps into count enable + direction.
// Optional QDEC_X1_EN macro selects x1 decoding (one pulse per full quadrature cycle); default is x4.
module quad_dir_decoder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 4,
  parameter int unsigned ERR_W       = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_a,
  input  logic             i_b,
  output logic             o_en,
  output logic             o_up_down,
  output logic             o_err,
  output logic [ERR_W-1:0] o_err_cnt
);

  localparam int unsigned FCNT_W      = $clog2(FILT_LEN) + 1;
  localparam int unsigned INIT_CYCLES = SYNC_STAGES + FILT_LEN + 1;
  localparam int unsigned INIT_W      = $clog2(INIT_CYCLES + 1);

  typedef enum logic {INIT, TRACK} state_t;

  logic [1:0] raw;
  logic [1:0] s;
  assign raw = {i_a, i_b};

  // Per-channel synchronizer followed by a persistence filter; bit 1 = A, bit 0 = B.
  for (genvar c = 0; c < 2; c++) begin : g_chan
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   filt_q;
    logic [FCNT_W-1:0]      fcnt_q;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];
    assign s[c]   = filt_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        sync_q <= '0;
        filt_q <= 1'b0;
        fcnt_q <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], raw[c]};
        if (synced == filt_q) begin
          fcnt_q <= '0;
        end else if (fcnt_q == FCNT_W'(FILT_LEN - 1)) begin
          filt_q <= synced;
          fcnt_q <= '0;
        end else begin
          fcnt_q <= fcnt_q + FCNT_W'(1);
        end
      end
    end
  end

  // Position of a state along the up-counting Gray sequence 00,10,11,01.
  function automatic logic [1:0] gray_idx(input logic [1:0] v);
    case (v)
      2'b00:   gray_idx = 2'd0;
      2'b10:   gray_idx = 2'd1;
      2'b11:   gray_idx = 2'd2;
      default: gray_idx = 2'd3;
    endcase
  endfunction

  state_t            state, state_nx;
  logic [INIT_W-1:0] init_cnt, init_cnt_nx;
  logic [1:0]        s_prev, s_prev_nx;
  logic              en_nx, err_nx, dir_nx, step_up;
  logic [ERR_W-1:0]  err_cnt_nx;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= INIT;
      init_cnt  <= '0;
      s_prev    <= 2'b00;
      o_en      <= 1'b0;
      o_err     <= 1'b0;
      o_up_down <= 1'b1;
      o_err_cnt <= '0;
    end else begin
      state     <= state_nx;
      init_cnt  <= init_cnt_nx;
      s_prev    <= s_prev_nx;
      o_en      <= en_nx;
      o_err     <= err_nx;
      o_up_down <= dir_nx;
      o_err_cnt <= err_cnt_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    init_cnt_nx = init_cnt;
    s_prev_nx   = s_prev;
    en_nx       = 1'b0;
    err_nx      = 1'b0;
    dir_nx      = o_up_down;
    err_cnt_nx  = o_err_cnt;
    step_up     = (gray_idx(s) == gray_idx(s_prev) + 2'd1);
    case (state)
      INIT: begin
        // Let the synchronizers and filters settle before trusting s.
        if (init_cnt == INIT_W'(INIT_CYCLES - 1)) begin
          s_prev_nx   = s;
          init_cnt_nx = '0;
          state_nx    = TRACK;
        end else begin
          init_cnt_nx = init_cnt + INIT_W'(1);
        end
      end
      TRACK: begin
        s_prev_nx = s;
        if ((s ^ s_prev) == 2'b11) begin
          err_nx = 1'b1;
          if (o_err_cnt != '1) begin
            err_cnt_nx = o_err_cnt + ERR_W'(1);
          end
        end else if (s != s_prev) begin
`ifdef QDEC_X1_EN
          if ((s_prev == 2'b01 && s == 2'b00) || (s_prev == 2'b00 && s == 2'b01)) begin
            en_nx  = 1'b1;
            dir_nx = step_up;
          end
`else
          en_nx  = 1'b1;
          dir_nx = step_up;
`endif
        end
      end
      default: state_nx = INIT;
    endcase
  end

endmodule
